// File: rtl/lc3_pkg.sv
// Shared LC3 register-file types and constants used by the writeback path.
package lc3_pkg;

    localparam int WORD_W     = 16;
    localparam int REG_ADDR_W = 3;
    localparam int NUM_REGS   = 8;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [WORD_W-1:0]     data;
    } rf_wr_t;

    // Relative age of the two holding slots when both are occupied.
    typedef enum logic [1:0] {
        AGE_NONE     = 2'd0,
        AGE_EX_OLDER = 2'd1,
        AGE_LD_OLDER = 2'd2
    } age_t;

endpackage

// File: rtl/regfile8x16.sv
// Eight 16-bit LC3 registers: one synchronous write port, two combinational read ports.
module regfile8x16
    import lc3_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  writeEN,
    input  logic [REG_ADDR_W-1:0] wrAddr,
    input  logic [WORD_W-1:0]     wrData,
    input  logic [REG_ADDR_W-1:0] rdAddrA,
    output logic [WORD_W-1:0]     rdDataA,
    input  logic [REG_ADDR_W-1:0] rdAddrB,
    output logic [WORD_W-1:0]     rdDataB
);

    logic [WORD_W-1:0] regs_q [NUM_REGS];

    assign rdDataA = regs_q[rdAddrA];
    assign rdDataB = regs_q[rdAddrB];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (writeEN) begin
            regs_q[wrAddr] <= wrData;
        end
    end

endmodule

// File: rtl/wr_hold_slot.sv
// One-deep holding register for a writeback request; can drain and refill on the same edge.
module wr_hold_slot
    import lc3_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [REG_ADDR_W-1:0] addr_i,
    input  logic [WORD_W-1:0]     data_i,
    input  logic                  drain_i,
    output logic                  ready_o,
    output logic                  accept_o,
    output logic                  occupied_o,
    output rf_wr_t                entry_o
);

    logic   occ_q, occ_d;
    rf_wr_t entry_q, entry_d;

    assign ready_o    = !occ_q || drain_i;
    assign accept_o   = valid_i && ready_o;
    assign occupied_o = occ_q;
    assign entry_o    = entry_q;

    always_comb begin
        occ_d   = occ_q;
        entry_d = entry_q;
        if (accept_o) begin
            occ_d        = 1'b1;
            entry_d.addr = addr_i;
            entry_d.data = data_i;
        end else if (drain_i) begin
            occ_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q   <= 1'b0;
            entry_q <= '0;
        end else begin
            occ_q   <= occ_d;
            entry_q <= entry_d;
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates the execute and load writeback slots onto the single regfile write port,
// oldest write first, and publishes which registers still have a write in flight.
module regfile_wr_arbiter
    import lc3_pkg::*;
#(
    parameter int DATA_W = WORD_W,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int NREGS  = NUM_REGS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              writeEN,
    output logic [ADDR_W-1:0] wrAddr,
    output logic [DATA_W-1:0] wrData,
    output logic              grant_ld,
    output logic [NREGS-1:0]  pending
);

    age_t   age_q, age_d;
    logic   rr_q, rr_d;
    logic   ex_occ, ld_occ, ex_acc, ld_acc;
    logic   ex_grant, ld_grant, sel_ld, tie_rr;
    logic   ex_occ_d, ld_occ_d;
    rf_wr_t ex_entry, ld_entry;

    wr_hold_slot u_ex_slot (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (ex_valid),
        .addr_i     (ex_addr),
        .data_i     (ex_data),
        .drain_i    (ex_grant),
        .ready_o    (ex_ready),
        .accept_o   (ex_acc),
        .occupied_o (ex_occ),
        .entry_o    (ex_entry)
    );

    wr_hold_slot u_ld_slot (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (ld_valid),
        .addr_i     (ld_addr),
        .data_i     (ld_data),
        .drain_i    (ld_grant),
        .ready_o    (ld_ready),
        .accept_o   (ld_acc),
        .occupied_o (ld_occ),
        .entry_o    (ld_entry)
    );

    // Same-edge tie to the same register always goes ex first so the load value lands last.
    always_comb begin
        sel_ld = 1'b0;
        tie_rr = 1'b0;
        if (ld_occ && !ex_occ) begin
            sel_ld = 1'b1;
        end else if (ex_occ && ld_occ) begin
            case (age_q)
                AGE_LD_OLDER: sel_ld = 1'b1;
                AGE_EX_OLDER: sel_ld = 1'b0;
                default: begin
                    if (ex_entry.addr != ld_entry.addr) begin
                        sel_ld = rr_q;
                        tie_rr = 1'b1;
                    end
                end
            endcase
        end
    end

    assign ex_grant = ex_occ && !sel_ld;
    assign ld_grant = ld_occ && sel_ld;
    assign ex_occ_d = ex_acc || (ex_occ && !ex_grant);
    assign ld_occ_d = ld_acc || (ld_occ && !ld_grant);

    always_comb begin
        age_d = age_q;
        rr_d  = rr_q ^ tie_rr;
        if (!ex_occ_d || !ld_occ_d) begin
            age_d = AGE_NONE;
        end else if (ex_acc && !ld_acc) begin
            age_d = AGE_LD_OLDER;
        end else if (ld_acc && !ex_acc) begin
            age_d = AGE_EX_OLDER;
        end else if (ex_acc && ld_acc) begin
            age_d = AGE_NONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            age_q <= AGE_NONE;
            rr_q  <= 1'b0;
        end else begin
            age_q <= age_d;
            rr_q  <= rr_d;
        end
    end

    assign writeEN  = ex_grant || ld_grant;
    assign grant_ld = ld_grant;
    assign wrAddr   = ld_grant ? ld_entry.addr : (ex_grant ? ex_entry.addr : '0);
    assign wrData   = ld_grant ? ld_entry.data : (ex_grant ? ex_entry.data : '0);

    // Decoded straight from slot flops, so decode never sees a combinational input path.
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_pending
        assign pending[gi] = (ex_occ && (ex_entry.addr == ADDR_W'(gi)))
                          || (ld_occ && (ld_entry.addr == ADDR_W'(gi)));
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench: arbiter feeding regfile8x16, checked against hand-computed values.
module tb_regfile_wr_arbiter;
    import lc3_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rf_rst;
    logic        ex_valid, ex_ready, ld_valid, ld_ready;
    logic [2:0]  ex_addr, ld_addr, wrAddr, rdAddrA, rdAddrB;
    logic [15:0] ex_data, ld_data, wrData, rdDataA, rdDataB;
    logic        writeEN, grant_ld;
    logic [7:0]  pending;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    regfile_wr_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .ex_valid (ex_valid),
        .ex_ready (ex_ready),
        .ex_addr  (ex_addr),
        .ex_data  (ex_data),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .writeEN  (writeEN),
        .wrAddr   (wrAddr),
        .wrData   (wrData),
        .grant_ld (grant_ld),
        .pending  (pending)
    );

    regfile8x16 u_rf (
        .clk     (clk),
        .rst     (rf_rst),
        .writeEN (writeEN),
        .wrAddr  (wrAddr),
        .wrData  (wrData),
        .rdAddrA (rdAddrA),
        .rdDataA (rdDataA),
        .rdAddrB (rdAddrB),
        .rdDataB (rdDataB)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic read_reg(input logic [2:0] a, output logic [15:0] d);
        rdAddrA = a;
        #1;
        d = rdDataA;
    endtask

    logic [15:0] rv;
    int ex_sent, ld_sent, writes, ex_w, ld_w, gaps;
    logic prev_g;

    initial begin
        rst = 1'b1; rf_rst = 1'b1;
        ex_valid = 1'b0; ld_valid = 1'b0;
        ex_addr = '0; ld_addr = '0; ex_data = '0; ld_data = '0;
        rdAddrA = '0; rdAddrB = '0;

        // 1. reset
        #40;
        rst = 1'b0; rf_rst = 1'b0;
        #1;
        chk("rst_wen", writeEN, 0);
        chk("rst_pending", pending, 8'h00);
        chk("rst_ex_ready", ex_ready, 1);
        chk("rst_ld_ready", ld_ready, 1);
        chk("rst_wraddr", wrAddr, 0);
        chk("rst_wrdata", wrData, 0);
        chk("rst_grant_ld", grant_ld, 0);
        for (int r = 0; r < 8; r++) begin
            read_reg(3'(r), rv);
            chk($sformatf("rst_R%0d", r), rv, 16'h0000);
        end
        $display("T1 reset done");

        // 2. single ex write
        @(negedge clk);
        ex_valid = 1'b1; ex_addr = 3'd2; ex_data = 16'd15;
        @(negedge clk);
        ex_valid = 1'b0;
        chk("t2_wen", writeEN, 1);
        chk("t2_wraddr", wrAddr, 2);
        chk("t2_wrdata", wrData, 15);
        chk("t2_grant_ld", grant_ld, 0);
        chk("t2_pending", pending, 8'h04);
        @(negedge clk);
        chk("t2_wen_after", writeEN, 0);
        chk("t2_pending_after", pending, 8'h00);
        read_reg(3'd2, rv);
        chk("t2_R2", rv, 16'd15);
        $display("T2 ex R2<=15");

        // 3. same-edge tie, different addresses
        ex_valid = 1'b1; ex_addr = 3'd4; ex_data = 16'd8;
        ld_valid = 1'b1; ld_addr = 3'd2; ld_data = 16'h1234;
        @(negedge clk);
        ex_valid = 1'b0; ld_valid = 1'b0;
        chk("t3_c1_wen", writeEN, 1);
        chk("t3_c1_grant_ld", grant_ld, 0);
        chk("t3_c1_wraddr", wrAddr, 4);
        chk("t3_c1_ld_ready", ld_ready, 0);
        chk("t3_c1_pending", pending, 8'h14);
        @(negedge clk);
        chk("t3_c2_wen", writeEN, 1);
        chk("t3_c2_grant_ld", grant_ld, 1);
        chk("t3_c2_wraddr", wrAddr, 2);
        chk("t3_c2_wrdata", wrData, 16'h1234);
        chk("t3_c2_ld_ready", ld_ready, 1);
        @(negedge clk);
        chk("t3_wen_idle", writeEN, 0);
        read_reg(3'd4, rv);
        chk("t3_R4", rv, 16'd8);
        read_reg(3'd2, rv);
        chk("t3_R2", rv, 16'h1234);
        $display("T3 tie R4<=8 R2<=1234");

        // 4. same-edge tie, same address: ex first, ld value final
        ex_valid = 1'b1; ex_addr = 3'd3; ex_data = 16'd1;
        ld_valid = 1'b1; ld_addr = 3'd3; ld_data = 16'd2;
        @(negedge clk);
        ex_valid = 1'b0; ld_valid = 1'b0;
        chk("t4_c1_grant_ld", grant_ld, 0);
        chk("t4_c1_wrdata", wrData, 1);
        chk("t4_c1_pending", pending, 8'h08);
        @(negedge clk);
        chk("t4_c2_grant_ld", grant_ld, 1);
        chk("t4_c2_wrdata", wrData, 2);
        chk("t4_c2_pending", pending, 8'h08);
        @(negedge clk);
        chk("t4_pending_clear", pending, 8'h00);
        read_reg(3'd3, rv);
        chk("t4_R3", rv, 16'd2);
        $display("T4 same-addr R3 final=2");

        // 5. both sources streaming, five beats each
        ex_sent = 0; ld_sent = 0; writes = 0; ex_w = 0; ld_w = 0; gaps = 0; prev_g = 1'b0;
        ex_valid = 1'b1; ex_addr = 3'd5; ex_data = 16'h5000;
        ld_valid = 1'b1; ld_addr = 3'd6; ld_data = 16'h6000;
        for (int c = 0; c < 30 && writes < 10; c++) begin
            if (ex_valid && ex_ready) ex_sent++;
            if (ld_valid && ld_ready) ld_sent++;
            @(negedge clk);
            if (writeEN) begin
                if (writes > 0) chk("t5_alternate", grant_ld, !prev_g);
                prev_g = grant_ld;
                writes++;
                if (grant_ld) ld_w++; else ex_w++;
            end else if (writes > 0) begin
                gaps++;
            end
            ex_valid = (ex_sent < 5);
            ex_data  = 16'h5000 + 16'(ex_sent);
            ld_valid = (ld_sent < 5);
            ld_data  = 16'h6000 + 16'(ld_sent);
        end
        ex_valid = 1'b0; ld_valid = 1'b0;
        chk("t5_writes", writes, 10);
        chk("t5_ex_writes", ex_w, 5);
        chk("t5_ld_writes", ld_w, 5);
        chk("t5_gaps", gaps, 0);
        @(negedge clk);
        chk("t5_wen_idle", writeEN, 0);
        chk("t5_pending", pending, 8'h00);
        read_reg(3'd5, rv);
        chk("t5_R5", rv, 16'h5004);
        read_reg(3'd6, rv);
        chk("t5_R6", rv, 16'h6004);
        $display("T5 stream ex=%0d ld=%0d writes", ex_w, ld_w);

        // 6. reset with both slots occupied
        ex_valid = 1'b1; ex_addr = 3'd1; ex_data = 16'hAAAA;
        ld_valid = 1'b1; ld_addr = 3'd7; ld_data = 16'hBBBB;
        @(posedge clk);
        #5;
        ex_valid = 1'b0; ld_valid = 1'b0;
        chk("t6_pending_pre", pending, 8'h82);
        chk("t6_wen_pre", writeEN, 1);
        rst = 1'b1;
        #1;
        chk("t6_wen_rst", writeEN, 0);
        chk("t6_pending_rst", pending, 8'h00);
        chk("t6_wraddr_rst", wrAddr, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_wen_after", writeEN, 0);
        chk("t6_ex_ready", ex_ready, 1);
        chk("t6_ld_ready", ld_ready, 1);
        read_reg(3'd1, rv);
        chk("t6_R1", rv, 16'h0000);
        read_reg(3'd7, rv);
        chk("t6_R7", rv, 16'h0000);
        $display("T6 mid-op reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
